// File: rtl/vedic_pkg.sv
// Shared definitions for the Vedic multiply/divide blocks: operand widths,
// counter width and the divider state encoding.
package vedic_pkg;

   localparam int DIVIDEND_W = 8;
   localparam int DIVISOR_W  = 4;
   localparam int CNT_W      = $clog2(DIVIDEND_W);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } div_state_t;

endpackage

// File: rtl/vedic_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and emit one quotient bit.
module vedic_div_step
   import vedic_pkg::*;
#(
   parameter int DW = DIVISOR_W
) (
   input  logic [DW:0]   p_cur,
   input  logic          q_msb,
   input  logic [DW-1:0] divisor,
   output logic [DW:0]   p_next,
   output logic          q_bit
);

   logic [DW:0]   shifted;
   logic [DW+1:0] diff;

   // One extra bit on the difference so its MSB acts as the borrow/sign flag.
   always_comb begin
      shifted = {p_cur[DW-1:0], q_msb};
      diff    = {1'b0, shifted} - {2'b00, divisor};
      if (diff[DW+1] == 1'b0) begin
         p_next = diff[DW:0];
         q_bit  = 1'b1;
      end else begin
         p_next = shifted;
         q_bit  = 1'b0;
      end
   end

endmodule

// File: rtl/vedic_div_8by4.sv
// Sequential restoring divider, one quotient bit per clock, framed by a
// start/busy/done handshake. Results are held until the next completion.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start; last result held on the outputs
//   ST_RUN  | one restoring step per clock, counter 0..DIVIDEND_W-1
//   ST_FIN  | done pulse for one cycle; start here is accepted as in IDLE
module vedic_div_8by4
   import vedic_pkg::*;
#(
   parameter int DIVIDEND_W_P = DIVIDEND_W,
   parameter int DIVISOR_W_P  = DIVISOR_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [DIVIDEND_W_P-1:0] dividend,
   input  logic [DIVISOR_W_P-1:0]  divisor,
   output logic                    busy,
   output logic                    done,
   output logic [DIVIDEND_W_P-1:0] quotient,
   output logic [DIVISOR_W_P-1:0]  remainder,
   output logic                    div_by_zero
);

   localparam int CW = (DIVIDEND_W_P > 1) ? $clog2(DIVIDEND_W_P) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIVIDEND_W_P - 1);

   div_state_t              state;
   logic [CW-1:0]           cnt;
   logic [DIVISOR_W_P:0]    p_reg;
   logic [DIVIDEND_W_P-1:0] q_reg;
   logic [DIVISOR_W_P-1:0]  dvs_reg;

   logic [DIVISOR_W_P:0]    p_next;
   logic                    q_bit;
   logic                    accept;

   vedic_div_step #(.DW(DIVISOR_W_P)) u_step (
      .p_cur   (p_reg),
      .q_msb   (q_reg[DIVIDEND_W_P-1]),
      .divisor (dvs_reg),
      .p_next  (p_next),
      .q_bit   (q_bit)
   );

   assign busy   = (state == ST_RUN);
   assign done   = (state == ST_FIN);
   assign accept = start && (state != ST_RUN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         p_reg       <= '0;
         q_reg       <= '0;
         dvs_reg     <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               p_reg <= p_next;
               q_reg <= {q_reg[DIVIDEND_W_P-2:0], q_bit};
               cnt   <= cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  state       <= ST_FIN;
                  quotient    <= {q_reg[DIVIDEND_W_P-2:0], q_bit};
                  remainder   <= p_next[DIVISOR_W_P-1:0];
                  div_by_zero <= 1'b0;
               end
            end
            default: begin
               if (accept) begin
                  q_reg   <= dividend;
                  p_reg   <= '0;
                  dvs_reg <= divisor;
                  cnt     <= '0;
                  // Zero divisor skips the iterations and reports the saturated result.
                  if (divisor == '0) begin
                     state       <= ST_FIN;
                     quotient    <= '1;
                     remainder   <= '0;
                     div_by_zero <= 1'b1;
                  end else begin
                     state <= ST_RUN;
                  end
               end else begin
                  state <= ST_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vedic_div_8by4.sv
// Self-checking bench for vedic_div_8by4: directed vector table, handshake and
// reset sequences, round-trip sweep and random operands against plain arithmetic.
module tb_vedic_div_8by4;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] dividend;
   logic [3:0] divisor;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [3:0] remainder;
   logic       div_by_zero;

   int total = 0;
   int bad   = 0;

   vedic_div_8by4 dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [3:0] b;
      logic [7:0] q;
      logic [3:0] r;
      logic       z;
      int         lat;
      int         nbusy;
   } vec_t;

   vec_t vecs[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Issue start from IDLE or FIN, return at the done cycle (or after a bound).
   task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                         output int lat, output int nbusy, output logic busy_at_done,
                         output logic [7:0] q, output logic [3:0] r, output logic z,
                         output logic timed_out);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      tick();
      start    = 1'b0;
      lat      = 1;
      nbusy    = 0;
      while (!done && lat < 20) begin
         if (busy) nbusy++;
         tick();
         lat++;
      end
      timed_out    = !done;
      busy_at_done = busy;
      q = quotient;
      r = remainder;
      z = div_by_zero;
   endtask

   task automatic ref_div(input logic [7:0] a, input logic [3:0] b,
                          output logic [7:0] q, output logic [3:0] r, output logic z);
      if (b == 0) begin
         q = 8'hFF; r = 4'h0; z = 1'b1;
      end else begin
         q = 8'(int'(a) / int'(b));
         r = 4'(int'(a) % int'(b));
         z = 1'b0;
      end
   endtask

   initial begin
      int         lat, nbusy, ndone;
      logic       bd, to, z;
      logic [7:0] q, eq;
      logic [3:0] r, er;
      logic       ez;

      vecs.push_back('{8'd6,   4'd3,  8'd2,   4'd0, 1'b0, 9, 8});
      vecs.push_back('{8'd255, 4'd4,  8'd63,  4'd3, 1'b0, 9, 8});
      vecs.push_back('{8'd225, 4'd15, 8'd15,  4'd0, 1'b0, 9, 8});
      vecs.push_back('{8'd9,   4'd0,  8'hFF,  4'd0, 1'b1, 1, 0});
      vecs.push_back('{8'd20,  4'd7,  8'd2,   4'd6, 1'b0, 9, 8});
      vecs.push_back('{8'd0,   4'd5,  8'd0,   4'd0, 1'b0, 9, 8});
      vecs.push_back('{8'd255, 4'd1,  8'd255, 4'd0, 1'b0, 9, 8});
      vecs.push_back('{8'd7,   4'd15, 8'd0,   4'd7, 1'b0, 9, 8});
      vecs.push_back('{8'd255, 4'd15, 8'd17,  4'd0, 1'b0, 9, 8});

      // Reset with start held high
      rst = 1'b1; start = 1'b1; dividend = 8'd77; divisor = 4'd5;
      tick(); tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_q", quotient, 0);
      check("rst_r", remainder, 0);
      check("rst_dbz", div_by_zero, 0);
      start = 1'b0;
      rst   = 1'b0;
      ndone = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (busy || done) ndone++;
      end
      check("idle_after_rst", ndone, 0);

      // Directed table
      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, lat, nbusy, bd, q, r, z, to);
         check($sformatf("vec%0d_timeout", i), to, 0);
         check($sformatf("vec%0d_q", i), q, vecs[i].q);
         check($sformatf("vec%0d_r", i), r, vecs[i].r);
         check($sformatf("vec%0d_dbz", i), z, vecs[i].z);
         check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
         check($sformatf("vec%0d_busycyc", i), nbusy, vecs[i].nbusy);
         check($sformatf("vec%0d_busy_at_done", i), bd, 0);
         tick();
         check($sformatf("vec%0d_done_pulse", i), done, 0);
         check($sformatf("vec%0d_hold_q", i), quotient, vecs[i].q);
      end

      // start re-asserted at busy cycle 3 with other operands is ignored
      start = 1'b1; dividend = 8'd200; divisor = 4'd5;
      tick();
      start = 1'b0; dividend = 8'd0; divisor = 4'd0;
      tick(); tick();
      start = 1'b1; dividend = 8'd13; divisor = 4'd2;
      tick();
      start = 1'b0;
      lat = 4;
      while (!done && lat < 20) begin tick(); lat++; end
      check("ign_lat", lat, 9);
      check("ign_q", quotient, 40);
      check("ign_r", remainder, 0);
      tick();
      check("ign_no_second_op", busy, 0);

      // Back-to-back: start in FIN; old result visible while the next runs
      run_op(8'd6, 8'd3, lat, nbusy, bd, q, r, z, to);
      check("b2b_first_q", q, 2);
      start = 1'b1; dividend = 8'd100; divisor = 4'd9;
      tick();
      start = 1'b0;
      check("b2b_busy", busy, 1);
      check("b2b_hold_q", quotient, 2);
      lat = 1;
      while (!done && lat < 20) begin tick(); lat++; end
      check("b2b_lat", lat, 9);
      check("b2b_q", quotient, 11);
      check("b2b_r", remainder, 1);
      tick();

      // Reset at busy cycle 4
      start = 1'b1; dividend = 8'd200; divisor = 4'd7;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_q", quotient, 0);
      check("midrst_r", remainder, 0);
      tick();
      rst = 1'b0;
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done || busy) ndone++;
      end
      check("midrst_no_done", ndone, 0);
      run_op(8'd100, 4'd9, lat, nbusy, bd, q, r, z, to);
      check("post_rst_q", q, 11);
      check("post_rst_r", r, 1);
      tick();

      // Round-trip sweep
      for (int a = 1; a <= 15; a++) begin
         for (int b = 1; b <= 15; b++) begin
            run_op(8'(a * b), 4'(b), lat, nbusy, bd, q, r, z, to);
            check($sformatf("rt_%0dx%0d_q", a, b), q, 8'(a));
            check($sformatf("rt_%0dx%0d_r", a, b), r, 0);
            tick();
         end
      end

      // Random operands against arithmetic reference and invariant
      for (int i = 0; i < 200; i++) begin
         logic [7:0] ra;
         logic [3:0] rb;
         ra = 8'($urandom_range(0, 255));
         rb = 4'($urandom_range(0, 15));
         ref_div(ra, rb, eq, er, ez);
         run_op(ra, rb, lat, nbusy, bd, q, r, z, to);
         check($sformatf("rnd%0d_q", i), q, eq);
         check($sformatf("rnd%0d_r", i), r, er);
         check($sformatf("rnd%0d_dbz", i), z, ez);
         check($sformatf("rnd%0d_lat", i), lat, (rb == 0) ? 1 : 9);
         if (rb != 0) begin
            check($sformatf("rnd%0d_inv", i), 32'(q) * 32'(rb) + 32'(r), 32'(ra));
            check($sformatf("rnd%0d_rlt", i), (r < rb) ? 1 : 0, 1);
         end
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
